// File: rtl/axi_lite_arbiter_2to1_if.sv
// AXI-Lite style bus bundle shared by the arbiter's upstream and downstream ports.
// There is no W-channel handshake: wdata/wstrb travel with the AW handshake.
interface axi_lite_interface #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master to one-slave AXI-Lite arbiter: one whole read or write at a time,
// round-robin on ties, combinational forwarding from the registered grant/state.
module axi_lite_arbiter_2to1 #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    axi_lite_interface.slave  m0,
    axi_lite_interface.slave  m1,
    axi_lite_interface.master s,
    output logic [1:0]        grant,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t state_r, state_s;
    logic [1:0] grant_r, grant_s;
    logic       last_grant_r, last_grant_s;   // 0 = m0, 1 = m1
    logic       busy_r;
    logic       req0_s, req1_s, pick_s, pick_aw_s;

    logic                    sel_s;
    logic [ADDR_WIDTH-1:0]   sel_araddr_s, sel_awaddr_s;
    logic [2:0]              sel_arprot_s, sel_awprot_s;
    logic                    sel_arvalid_s, sel_awvalid_s, sel_rready_s, sel_bready_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;
    logic [DATA_WIDTH/8-1:0] sel_wstrb_s;

    assign req0_s = m0.arvalid | m0.awvalid;
    assign req1_s = m1.arvalid | m1.awvalid;

    // Owner of the current transaction, taken from the registered grant
    assign sel_s         = grant_r[1];
    assign sel_araddr_s  = sel_s ? m1.araddr  : m0.araddr;
    assign sel_arprot_s  = sel_s ? m1.arprot  : m0.arprot;
    assign sel_arvalid_s = sel_s ? m1.arvalid : m0.arvalid;
    assign sel_rready_s  = sel_s ? m1.rready  : m0.rready;
    assign sel_awaddr_s  = sel_s ? m1.awaddr  : m0.awaddr;
    assign sel_awprot_s  = sel_s ? m1.awprot  : m0.awprot;
    assign sel_awvalid_s = sel_s ? m1.awvalid : m0.awvalid;
    assign sel_wdata_s   = sel_s ? m1.wdata   : m0.wdata;
    assign sel_wstrb_s   = sel_s ? m1.wstrb   : m0.wstrb;
    assign sel_bready_s  = sel_s ? m1.bready  : m0.bready;

    assign grant = grant_r;
    assign busy  = busy_r;

    // Next-state, next-grant and round-robin bookkeeping
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        pick_s       = 1'b0;
        pick_aw_s    = 1'b0;
        if (req0_s && req1_s) begin
            pick_s = ~last_grant_r;
        end else begin
            pick_s = req1_s;
        end
        pick_aw_s = pick_s ? m1.awvalid : m0.awvalid;
        case (state_r)
            IDLE: begin
                if (req0_s || req1_s) begin
                    grant_s = pick_s ? 2'b10 : 2'b01;
                    state_s = pick_aw_s ? WR_ADDR : RD_ADDR;
                end else begin
                    grant_s = 2'b00;
                    state_s = IDLE;
                end
            end
            RD_ADDR: begin
                if (sel_arvalid_s && s.arready) begin
                    state_s = RD_DATA;
                end else begin
                    state_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (s.rvalid && sel_rready_s) begin
                    state_s      = IDLE;
                    grant_s      = 2'b00;
                    last_grant_s = sel_s;
                end else begin
                    state_s = RD_DATA;
                end
            end
            WR_ADDR: begin
                if (sel_awvalid_s && s.awready) begin
                    state_s = WR_RESP;
                end else begin
                    state_s = WR_ADDR;
                end
            end
            WR_RESP: begin
                if (s.bvalid && sel_bready_s) begin
                    state_s      = IDLE;
                    grant_s      = 2'b00;
                    last_grant_s = sel_s;
                end else begin
                    state_s = WR_RESP;
                end
            end
            default: begin
                state_s = IDLE;
                grant_s = 2'b00;
            end
        endcase
    end

    // State, grant, tie-break history and busy flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            grant_r      <= 2'b00;
            last_grant_r <= 1'b1;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            busy_r       <= (state_s != IDLE);
        end
    end

    // Channel routing: only the active channel of the owning master is connected
    always_comb begin
        s.araddr   = {ADDR_WIDTH{1'b0}};
        s.arprot   = 3'b000;
        s.arvalid  = 1'b0;
        s.rready   = 1'b0;
        s.awaddr   = {ADDR_WIDTH{1'b0}};
        s.awprot   = 3'b000;
        s.awvalid  = 1'b0;
        s.wdata    = {DATA_WIDTH{1'b0}};
        s.wstrb    = {(DATA_WIDTH/8){1'b0}};
        s.bready   = 1'b0;
        m0.arready = 1'b0;
        m0.rdata   = {DATA_WIDTH{1'b0}};
        m0.rresp   = 2'b00;
        m0.rvalid  = 1'b0;
        m0.awready = 1'b0;
        m0.bresp   = 2'b00;
        m0.bvalid  = 1'b0;
        m1.arready = 1'b0;
        m1.rdata   = {DATA_WIDTH{1'b0}};
        m1.rresp   = 2'b00;
        m1.rvalid  = 1'b0;
        m1.awready = 1'b0;
        m1.bresp   = 2'b00;
        m1.bvalid  = 1'b0;
        case (state_r)
            RD_ADDR: begin
                s.araddr  = sel_araddr_s;
                s.arprot  = sel_arprot_s;
                s.arvalid = sel_arvalid_s;
                if (sel_s) begin
                    m1.arready = s.arready;
                end else begin
                    m0.arready = s.arready;
                end
            end
            RD_DATA: begin
                s.rready = sel_rready_s;
                if (sel_s) begin
                    m1.rdata  = s.rdata;
                    m1.rresp  = s.rresp;
                    m1.rvalid = s.rvalid;
                end else begin
                    m0.rdata  = s.rdata;
                    m0.rresp  = s.rresp;
                    m0.rvalid = s.rvalid;
                end
            end
            WR_ADDR: begin
                s.awaddr  = sel_awaddr_s;
                s.awprot  = sel_awprot_s;
                s.awvalid = sel_awvalid_s;
                s.wdata   = sel_wdata_s;
                s.wstrb   = sel_wstrb_s;
                if (sel_s) begin
                    m1.awready = s.awready;
                end else begin
                    m0.awready = s.awready;
                end
            end
            WR_RESP: begin
                s.bready = sel_bready_s;
                if (sel_s) begin
                    m1.bresp  = s.bresp;
                    m1.bvalid = s.bvalid;
                end else begin
                    m0.bresp  = s.bresp;
                    m0.bvalid = s.bvalid;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Scoreboard bench for axi_lite_arbiter_2to1: expected responses are queued per
// master when a request is driven and popped when that master sees the response.
module tb_axi_lite_arbiter_2to1;

    logic       clk;
    logic       rst;
    logic [1:0] grant;
    logic       busy;

    axi_lite_interface #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) m0_if ();
    axi_lite_interface #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) m1_if ();
    axi_lite_interface #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) s_if ();

    axi_lite_arbiter_2to1 #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .reset (rst),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if),
        .grant (grant),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Master-side drive variables, index 0 = m0, 1 = m1
    logic [7:0] awaddr_v [2];
    logic [7:0] wdata_v  [2];
    logic [7:0] araddr_v [2];
    logic [1:0] awvalid_v, arvalid_v, rready_v, bready_v;

    assign m0_if.awaddr  = awaddr_v[0];
    assign m0_if.awprot  = 3'b000;
    assign m0_if.awvalid = awvalid_v[0];
    assign m0_if.wdata   = wdata_v[0];
    assign m0_if.wstrb   = 1'b1;
    assign m0_if.bready  = bready_v[0];
    assign m0_if.araddr  = araddr_v[0];
    assign m0_if.arprot  = 3'b000;
    assign m0_if.arvalid = arvalid_v[0];
    assign m0_if.rready  = rready_v[0];
    assign m1_if.awaddr  = awaddr_v[1];
    assign m1_if.awprot  = 3'b000;
    assign m1_if.awvalid = awvalid_v[1];
    assign m1_if.wdata   = wdata_v[1];
    assign m1_if.wstrb   = 1'b1;
    assign m1_if.bready  = bready_v[1];
    assign m1_if.araddr  = araddr_v[1];
    assign m1_if.arprot  = 3'b000;
    assign m1_if.arvalid = arvalid_v[1];
    assign m1_if.rready  = rready_v[1];

    wire [1:0] arready_w = {m1_if.arready, m0_if.arready};
    wire [1:0] awready_w = {m1_if.awready, m0_if.awready};
    wire [1:0] rvalid_w  = {m1_if.rvalid,  m0_if.rvalid};
    wire [1:0] bvalid_w  = {m1_if.bvalid,  m0_if.bvalid};
    logic [7:0] rdata_w [2];
    logic [1:0] rresp_w [2];
    logic [1:0] bresp_w [2];
    assign rdata_w[0] = m0_if.rdata;
    assign rdata_w[1] = m1_if.rdata;
    assign rresp_w[0] = m0_if.rresp;
    assign rresp_w[1] = m1_if.rresp;
    assign bresp_w[0] = m0_if.bresp;
    assign bresp_w[1] = m1_if.bresp;

    // Slave model: *_cycles = number of cycles the channel waits, including the handshake cycle
    int ar_cycles = 1, r_cycles = 1, aw_cycles = 1, b_cycles = 1;
    int ar_cnt, r_cnt, aw_cnt, b_cnt;
    logic r_pend, b_pend;
    logic [7:0] raddr, baddr, bdata;
    wire s_arready_c = s_if.arvalid && (ar_cnt == ar_cycles - 1);
    wire s_rvalid_c  = r_pend && (r_cnt == r_cycles - 1);
    wire s_awready_c = s_if.awvalid && (aw_cnt == aw_cycles - 1);
    wire s_bvalid_c  = b_pend && (b_cnt == b_cycles - 1);
    assign s_if.arready = s_arready_c;
    assign s_if.rvalid  = s_rvalid_c;
    assign s_if.rdata   = raddr + 8'h95;
    assign s_if.rresp   = raddr[7:6];
    assign s_if.awready = s_awready_c;
    assign s_if.bvalid  = s_bvalid_c;
    assign s_if.bresp   = baddr[7:6] ^ bdata[1:0];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0;
            raddr <= 8'h00; baddr <= 8'h00; bdata <= 8'h00;
        end else begin
            if (s_if.arvalid && s_arready_c) begin
                ar_cnt <= 0; r_pend <= 1'b1; r_cnt <= 0; raddr <= s_if.araddr;
            end else if (s_if.arvalid) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (s_rvalid_c && s_if.rready) r_pend <= 1'b0;
            else if (r_pend && !s_rvalid_c) r_cnt <= r_cnt + 1;
            if (s_if.awvalid && s_awready_c) begin
                aw_cnt <= 0; b_pend <= 1'b1; b_cnt <= 0;
                baddr <= s_if.awaddr; bdata <= s_if.wdata;
            end else if (s_if.awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (s_bvalid_c && s_if.bready) b_pend <= 1'b0;
            else if (b_pend && !s_bvalid_c) b_cnt <= b_cnt + 1;
        end
    end

    int n_tests = 0, n_fail = 0;
    int spur = 0, m1_rvalid_cnt = 0, rd_addr_cyc = 0, rd_data_cyc = 0, cyc = 0;
    logic [1:0] gprev = 2'b00;
    logic [1:0] glog [$];
    int         gcyc [$];
    int         done_log [$];
    logic [9:0] exp_r0 [$], exp_r1 [$];
    logic [1:0] exp_b0 [$], exp_b1 [$];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic collect(input int i);
        logic [9:0] rgot, rexp;
        logic [1:0] bgot, bexp;
        if (rvalid_w[i] && rready_v[i]) begin
            rgot = {rresp_w[i], rdata_w[i]};
            if (i == 0 && exp_r0.size() > 0) rexp = exp_r0.pop_front();
            else if (i == 1 && exp_r1.size() > 0) rexp = exp_r1.pop_front();
            else rexp = ~rgot;
            check_value($sformatf("rd_resp_m%0d", i), 32'(rgot), 32'(rexp));
            done_log.push_back(i * 2);
        end
        if (bvalid_w[i] && bready_v[i]) begin
            bgot = bresp_w[i];
            if (i == 0 && exp_b0.size() > 0) bexp = exp_b0.pop_front();
            else if (i == 1 && exp_b1.size() > 0) bexp = exp_b1.pop_front();
            else bexp = ~bgot;
            check_value($sformatf("wr_resp_m%0d", i), 32'(bgot), 32'(bexp));
            done_log.push_back(i * 2 + 1);
        end
    endtask

    // Response monitor, isolation watch and grant trace, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                collect(0);
                collect(1);
                if (grant != 2'b01 && (arready_w[0] || awready_w[0] || rvalid_w[0] || bvalid_w[0] ||
                    rdata_w[0] != 8'h00 || rresp_w[0] != 2'b00 || bresp_w[0] != 2'b00)) spur++;
                if (grant != 2'b10 && (arready_w[1] || awready_w[1] || rvalid_w[1] || bvalid_w[1] ||
                    rdata_w[1] != 8'h00 || rresp_w[1] != 2'b00 || bresp_w[1] != 2'b00)) spur++;
                if (rvalid_w[1]) m1_rvalid_cnt++;
                if (s_if.arvalid) rd_addr_cyc++;
                if (s_if.rready) rd_data_cyc++;
                if (grant != gprev) begin
                    glog.push_back(grant);
                    gcyc.push_back(cyc);
                    gprev = grant;
                end
            end
        end
    end

    task automatic do_write(input int i, input logic [7:0] addr, input logic [7:0] data);
        int n;
        awaddr_v[i] = addr;
        wdata_v[i]  = data;
        awvalid_v[i] = 1'b1;
        if (i == 0) exp_b0.push_back(addr[7:6] ^ data[1:0]);
        else exp_b1.push_back(addr[7:6] ^ data[1:0]);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!awready_w[i] && n < 200);
        if (!awready_w[i]) check_value($sformatf("aw_hs_timeout_m%0d", i), 32'(awready_w[i]), 32'd1);
        @(posedge clk);
        #1;
        awvalid_v[i] = 1'b0;
    endtask

    task automatic do_read(input int i, input logic [7:0] addr);
        int n;
        araddr_v[i] = addr;
        arvalid_v[i] = 1'b1;
        if (i == 0) exp_r0.push_back({addr[7:6], addr + 8'h95});
        else exp_r1.push_back({addr[7:6], addr + 8'h95});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!arready_w[i] && n < 200);
        if (!arready_w[i]) check_value($sformatf("ar_hs_timeout_m%0d", i), 32'(arready_w[i]), 32'd1);
        @(posedge clk);
        #1;
        arvalid_v[i] = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((exp_r0.size() != 0 || exp_r1.size() != 0 || exp_b0.size() != 0 ||
                exp_b1.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_value({tag, "_done"}, 32'(n < 500), 32'd1);
        @(negedge clk);
    endtask

    task automatic clear_logs();
        exp_r0.delete(); exp_r1.delete(); exp_b0.delete(); exp_b1.delete();
        glog.delete(); gcyc.delete(); done_log.delete();
        gprev = 2'b00;
        spur = 0; m1_rvalid_cnt = 0; rd_addr_cyc = 0; rd_data_cyc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] gnz [$];

    initial begin
        rst = 1'b0;
        awvalid_v = 2'b00; arvalid_v = 2'b00; rready_v = 2'b11; bready_v = 2'b11;
        for (int i = 0; i < 2; i++) begin
            awaddr_v[i] = 8'h00; wdata_v[i] = 8'h00; araddr_v[i] = 8'h00;
        end
        // Requests held during reset must not leak through
        awvalid_v = 2'b01;
        arvalid_v = 2'b10;
        repeat (2) @(negedge clk);
        check_value("rst_grant", 32'(grant), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_s_valid_ready", 32'({s_if.arvalid, s_if.awvalid, s_if.rready, s_if.bready}), 32'd0);
        check_value("rst_m_valid_ready", 32'({arready_w, awready_w, rvalid_w, bvalid_w}), 32'd0);
        awvalid_v = 2'b00;
        arvalid_v = 2'b00;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // m0 read of 0x10, slave answers 0xA5/OKAY; m1 must stay quiet
        do_read(0, 8'h10);
        wait_done("rd_m0_0x10");
        check_value("m1_rvalid_quiet", 32'(m1_rvalid_cnt), 32'd0);
        do_read(1, 8'hC4);
        wait_done("rd_m1_0xC4");

        // Simultaneous writes after reset: m0 first, one idle cycle, then m1
        do_reset();
        fork
            do_write(0, 8'h41, 8'h02);
            do_write(1, 8'h82, 8'h01);
        join
        wait_done("tie_wr");
        check_value("tie_glog_size", 32'(glog.size() >= 3), 32'd1);
        check_value("tie_grant0", 32'(glog[0]), 32'd1);
        check_value("tie_grant1", 32'(glog[1]), 32'd0);
        check_value("tie_grant2", 32'(glog[2]), 32'd2);
        check_value("tie_idle_gap", 32'(gcyc[2] - gcyc[1]), 32'd1);

        // m1 holds aw and ar together: write first, then the read
        do_reset();
        fork
            do_write(1, 8'hC0, 8'h03);
            do_read(1, 8'h55);
        join
        wait_done("wr_then_rd");
        check_value("wr_rd_count", 32'(done_log.size()), 32'd2);
        check_value("wr_rd_first_is_wr", 32'(done_log[0]), 32'd3);
        check_value("wr_rd_second_is_rd", 32'(done_log[1]), 32'd2);

        // Slow slave: RD_ADDR held 3 cycles, RD_DATA held 2 cycles
        do_reset();
        ar_cycles = 3;
        r_cycles = 2;
        do_read(0, 8'h3C);
        wait_done("slow_rd");
        check_value("slow_rd_addr_cycles", 32'(rd_addr_cyc), 32'd3);
        check_value("slow_rd_data_cycles", 32'(rd_data_cyc), 32'd2);
        check_value("slow_rd_spurious", 32'(spur), 32'd0);
        ar_cycles = 1;
        r_cycles = 1;

        // Reset pulse while waiting in WR_RESP
        do_reset();
        b_cycles = 10;
        do_write(0, 8'h20, 8'h01);
        @(negedge clk);
        check_value("wr_resp_reached", 32'(s_if.bready), 32'd1);
        rst = 1'b0;
        #1;
        check_value("midrst_busy", 32'(busy), 32'd0);
        check_value("midrst_grant", 32'(grant), 32'd0);
        check_value("midrst_s_bready", 32'(s_if.bready), 32'd0);
        clear_logs();
        b_cycles = 1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_write(1, 8'h84, 8'h03);
        wait_done("wr_after_rst");
        check_value("after_rst_done_count", 32'(done_log.size()), 32'd1);
        check_value("after_rst_done_owner", 32'(done_log[0]), 32'd3);

        // Continuous contention: strict alternation, four grants each
        do_reset();
        fork
            for (int k = 0; k < 4; k++) do_write(0, 8'h10 + 8'(k), 8'(k));
            for (int k = 0; k < 4; k++) do_write(1, 8'hD0 + 8'(k), 8'(k + 1));
        join
        wait_done("alternation");
        gnz.delete();
        foreach (glog[j]) if (glog[j] != 2'b00) gnz.push_back(glog[j]);
        check_value("alt_grant_count", 32'(gnz.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            check_value($sformatf("alt_grant_%0d", k), 32'(gnz[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
        check_value("alt_spurious", 32'(spur), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation time limit reached, expected completion");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/axi_lite_arbiter_2to1.md
AXI_LITE_ARBITER_2TO1 -- requirements
Module: axi_lite_arbiter_2to1

Interface
REQ-001: Parameter ADDR_WIDTH, default 8, SHALL be the address width of all ports.
REQ-002: Parameter DATA_WIDTH, default 8, SHALL be the data width of all ports; strobe width is DATA_WIDTH/8.
REQ-003: Port clk, input, 1, SHALL be the single clock; all logic is rising-edge clocked.
REQ-004: Port reset, input, 1, SHALL be the reset: asynchronous, active-low (asserted at 0).
REQ-005: Port m0, axi_lite_interface, -, SHALL be upstream master 0. The block drives arready, rdata, rresp, rvalid, awready, bresp and bvalid, and samples the rest.
REQ-006: Port m1, axi_lite_interface, -, SHALL be upstream master 1, with the same directions as m0.
REQ-007: Port s, axi_lite_interface, -, SHALL be the shared downstream slave, with directions opposite to m0.
REQ-008: Port grant, output, 2, SHALL be one-hot owner status: bit0 = m0, bit1 = m1, 00 = none.
REQ-009: Port busy, output, 1, SHALL be 1 whenever the state is not IDLE.

Function
REQ-010: The block SHALL serve exactly one whole transaction (read or write) at a time. The FSM states are IDLE, RD_ADDR, RD_DATA, WR_ADDR and WR_RESP.
REQ-011: Master i requests in a cycle when its arvalid or awvalid is 1.
REQ-012: In IDLE with exactly one requester, that master SHALL be granted at the next edge.
REQ-013: In IDLE with both masters requesting, the master other than last_grant SHALL be granted. last_grant resets to m1, so m0 wins the first tie.
REQ-014: The granted master's type SHALL be chosen in IDLE. awvalid goes to WR_ADDR, else arvalid goes to RD_ADDR, so write beats read within one master.
REQ-015: The grant and the type SHALL be registered in IDLE and held until the transaction completes. grant updates at the same edge as the IDLE exit.
REQ-016: In RD_ADDR, s.araddr/arprot/arvalid SHALL equal the granted master's signals, and the granted master's arready SHALL equal s.arready.
REQ-017: On s.arvalid & s.arready in RD_ADDR, the FSM SHALL move to RD_DATA.
REQ-018: In RD_DATA, s.rdata/rresp/rvalid SHALL be routed to the granted master only, and s.rready SHALL equal that master's rready.
REQ-019: On rvalid & rready in RD_DATA, the FSM SHALL move to IDLE and set last_grant to the granted master.
REQ-020: In WR_ADDR, s.awaddr/awprot/awvalid/wdata/wstrb SHALL equal the granted master's signals. Write data is qualified by the aw handshake, since the interface has no wvalid/wready.
REQ-021: In WR_ADDR, the granted master's awready SHALL equal s.awready, and on awvalid & awready the FSM SHALL move to WR_RESP.
REQ-022: In WR_RESP, s.bresp/bvalid SHALL be routed to the granted master, and s.bready SHALL equal that master's bready.
REQ-023: On bvalid & bready in WR_RESP, the FSM SHALL move to IDLE and update last_grant.
REQ-024: The non-granted master SHALL see arready, awready, rvalid and bvalid held at 0, and its rdata/rresp/bresp at 0.
REQ-025: Toward the slave, all valid/ready outputs SHALL be 0 in IDLE and in states where they do not apply; address/data buses are don't-care but driven to 0.
REQ-026: Forwarding in the active states SHALL be combinational from registered grant and state, adding zero-cycle latency per handshake.
REQ-027: Arbitration overhead SHALL be exactly one IDLE cycle between back-to-back transactions.
REQ-028: A master dropping its valid before its handshake SHALL NOT abort the transaction. The FSM waits; the AXI rule forbids the drop anyway.
REQ-029: A request from the other master during an active transaction SHALL be ignored until IDLE.

Reset
REQ-030: While reset = 0, the FSM SHALL be IDLE, grant = 00, busy = 0 and last_grant = m1, and all valid/ready outputs on every port SHALL be 0, asynchronously.
REQ-031: A reset asserted mid-transaction SHALL abandon the transaction with no response issued. After release, arbitration restarts from the tie-break of REQ-013.
REQ-032: Outputs SHALL be valid from the first rising edge after reset deassertion.

Verification
REQ-033: m0 read of addr 0x10 while the slave returns 0xA5 with OKAY -> m0 sees rdata = 0xA5, rresp = 00, and m1 sees rvalid held at 0 throughout.
REQ-034: m0 and m1 both assert awvalid in the same cycle after reset -> m0 granted first; after its bvalid/bready, one IDLE cycle, then m1 granted; grant sequence 01, 00, 10.
REQ-035: m1 holds both awvalid and arvalid -> the write (WR_ADDR) is served first, then the read on the next grant.
REQ-036: The slave delays arready by 3 cycles and rvalid by 2 cycles -> the FSM holds RD_ADDR for 3 cycles and RD_DATA for 2 cycles, with no spurious handshakes on m0/m1.
REQ-037: reset = 0 pulsed while in WR_RESP -> busy = 0, grant = 00 and s.bready = 0 immediately; the next transaction completes normally.
REQ-038: Continuous requests from both masters for 8 transactions -> strict alternation m0, m1, m0, ..., four grants each.
